i2c_master_ctrl: RTL and testbench

// - I2C controller (master) that issues single-byte register writes/reads to the BLDC

---
 rtl/i2c_master_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte register write/read I2C master with open-drain SCL/SDA enables.
// Optional macro I2C_CLK_STRETCH_EN lets a target stretch SCL during the high quarter.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] START  = 4'd1;
    localparam logic [3:0] ADDR_W = 4'd2;
    localparam logic [3:0] REG    = 4'd3;
    localparam logic [3:0] DATA_W = 4'd4;
    localparam logic [3:0] RSTART = 4'd5;
    localparam logic [3:0] ADDR_R = 4'd6;
    localparam logic [3:0] DATA_R = 4'd7;
    localparam logic [3:0] STOP   = 4'd8;

    logic [3:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       quarter;
    logic [3:0]       bit_cnt;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic             ack_bit;
    logic             rw_q;
    logic [6:0]       addr_q;
    logic [7:0]       reg_q;
    logic [7:0]       wdata_q;
    logic [1:0]       scl_sync_r;
    logic [1:0]       sda_sync_r;
    logic             scl_sync;
    logic             sda_sync;
    logic             stretch_hold;
    logic             quarter_end;
    logic             is_tx_byte;
    logic             is_byte;
    logic             last_bit;
    logic             scl_oe_next;
    logic             sda_oe_next;

    // Two-flop synchronisers for the pin levels; both idle high like the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
        end
    end

    assign scl_sync = scl_sync_r[1];
    assign sda_sync = sda_sync_r[1];

`ifdef I2C_CLK_STRETCH_EN
    assign stretch_hold = (state != IDLE) && (quarter == 2'd2) && !scl_sync;
`else
    logic unused_scl_sync;
    assign unused_scl_sync = scl_sync;
    assign stretch_hold    = 1'b0;
`endif

    assign quarter_end = (state != IDLE) && (div_cnt == DIV_LAST) && !stretch_hold;
    assign is_tx_byte  = (state == ADDR_W) || (state == REG) ||
                         (state == DATA_W) || (state == ADDR_R);
    assign is_byte     = is_tx_byte || (state == DATA_R);
    assign last_bit    = (bit_cnt == 4'd8);

    // The done cycle is still counted as busy so a command there waits one cycle.
    assign cmd_ready = (state == IDLE) && !done;
    assign busy      = !cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            quarter  <= 2'd0;
            bit_cnt  <= 4'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            ack_bit  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= 7'h00;
            reg_q    <= 8'h00;
            wdata_q  <= 8'h00;
            rdata    <= 8'h00;
            done     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid && cmd_ready) begin
                    rw_q    <= cmd_rw;
                    addr_q  <= cmd_addr;
                    reg_q   <= cmd_reg;
                    wdata_q <= cmd_wdata;
                    ack_err <= 1'b0;
                    state   <= START;
                    div_cnt <= '0;
                    quarter <= 2'd0;
                    bit_cnt <= 4'd0;
                end
            end else begin
                if (quarter_end) begin
                    div_cnt <= '0;
                end else if (!stretch_hold) begin
                    div_cnt <= div_cnt + DIV_ONE;
                end

                if (quarter_end) begin
                    quarter <= quarter + 2'd1;

                    if ((quarter == 2'd2) && is_byte) begin
                        if (last_bit) begin
                            ack_bit <= sda_sync;
                        end else if (state == DATA_R) begin
                            rx_shift <= {rx_shift[6:0], sda_sync};
                        end
                    end

                    // End of a 4-quarter step: move to the next bit or the next phase.
                    if (quarter == 2'd3) begin
                        case (state)
                            START: begin
                                state    <= ADDR_W;
                                tx_shift <= {addr_q, 1'b0};
                                bit_cnt  <= 4'd0;
                            end
                            RSTART: begin
                                state    <= ADDR_R;
                                tx_shift <= {addr_q, 1'b1};
                                bit_cnt  <= 4'd0;
                            end
                            STOP: begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                            default: begin
                                if (!last_bit) begin
                                    bit_cnt  <= bit_cnt + 4'd1;
                                    tx_shift <= {tx_shift[6:0], 1'b0};
                                end else begin
                                    bit_cnt <= 4'd0;
                                    case (state)
                                        ADDR_W: begin
                                            if (ack_bit) begin
                                                ack_err <= 1'b1;
                                                state   <= STOP;
                                            end else begin
                                                state    <= REG;
                                                tx_shift <= reg_q;
                                            end
                                        end
                                        REG: begin
                                            if (ack_bit) begin
                                                ack_err <= 1'b1;
                                                state   <= STOP;
                                            end else if (rw_q) begin
                                                state <= RSTART;
                                            end else begin
                                                state    <= DATA_W;
                                                tx_shift <= wdata_q;
                                            end
                                        end
                                        DATA_W: begin
                                            if (ack_bit) begin
                                                ack_err <= 1'b1;
                                            end
                                            state <= STOP;
                                        end
                                        ADDR_R: begin
                                            if (ack_bit) begin
                                                ack_err <= 1'b1;
                                                state   <= STOP;
                                            end else begin
                                                state <= DATA_R;
                                            end
                                        end
                                        DATA_R: begin
                                            rdata <= rx_shift;
                                            state <= STOP;
                                        end
                                        default: begin
                                            state <= STOP;
                                        end
                                    endcase
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

    // Line pattern per quarter; on the 9th bit of every byte SDA is released
    // (target ACK on writes, master NACK on the read data byte).
    always_comb begin
        scl_oe_next = 1'b0;
        sda_oe_next = 1'b0;
        case (state)
            IDLE: begin
                scl_oe_next = 1'b0;
                sda_oe_next = 1'b0;
            end
            START: begin
                scl_oe_next = (quarter == 2'd3);
                sda_oe_next = quarter[1];
            end
            RSTART: begin
                scl_oe_next = (quarter == 2'd0) || (quarter == 2'd3);
                sda_oe_next = quarter[1];
            end
            STOP: begin
                scl_oe_next = (quarter == 2'd0);
                sda_oe_next = (quarter != 2'd3);
            end
            DATA_R: begin
                scl_oe_next = (quarter == 2'd0) || (quarter == 2'd3);
                sda_oe_next = 1'b0;
            end
            default: begin
                scl_oe_next = (quarter == 2'd0) || (quarter == 2'd3);
                sda_oe_next = is_tx_byte && !last_bit && !tx_shift[7];
            end
        endcase
    end

    // Registered pin enables keep the open-drain outputs glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
        end else begin
            scl_oe <= scl_oe_next;
            sda_oe <= sda_oe_next;
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a cycle-sampled I2C target model.
// The stretching scenario only runs when I2C_CLK_STRETCH_EN is defined.
module tb_i2c_master_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic [7:0] rdata;
    logic       done;
    logic       ack_err;
    logic       busy;
    logic       scl_line;
    logic       sda_line;
    logic       scl_oe;
    logic       sda_oe;

    int n_cmp;
    int n_err;
    int cycles;

    // Target model configuration (written only by the stimulus block)
    logic       tgt_clear;
    logic       tgt_present;
    int         nack_idx;
    logic [7:0] read_byte;
    logic       stretch_en;

    // Target model state (written only by the target process)
    logic       prev_scl;
    logic       prev_sda;
    int         bit_n;
    logic       tx_mode;
    logic       first_byte;
    logic       rd_addr_ok;
    logic       tgt_drive;
    logic       master_ack;
    logic       ack_now;
    logic [7:0] shreg;
    int         rx_n;
    int         starts;
    int         stops;
    int         stretch_cnt;
    logic [7:0] rx_log [0:7];

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
        .rdata     (rdata),
        .done      (done),
        .ack_err   (ack_err),
        .busy      (busy),
        .scl_in    (scl_line),
        .sda_in    (sda_line),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    assign scl_line = !(scl_oe || (stretch_cnt > 0));
    assign sda_line = !(sda_oe || tgt_drive);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target: detects START/STOP, shifts bits on SCL rise, changes SDA after SCL fall.
    always @(posedge clk) begin
        prev_scl <= scl_line;
        prev_sda <= sda_line;
        if (stretch_cnt > 0) stretch_cnt <= stretch_cnt - 1;
        if (tgt_clear) begin
            bit_n       <= 0;
            tx_mode     <= 1'b0;
            first_byte  <= 1'b1;
            rd_addr_ok  <= 1'b0;
            tgt_drive   <= 1'b0;
            master_ack  <= 1'b0;
            shreg       <= 8'h00;
            rx_n        <= 0;
            starts      <= 0;
            stops       <= 0;
            stretch_cnt <= 0;
            for (int i = 0; i < 8; i++) rx_log[i] <= 8'h00;
        end else if (prev_scl && scl_line && prev_sda && !sda_line) begin
            starts     <= starts + 1;
            bit_n      <= 0;
            tx_mode    <= 1'b0;
            first_byte <= 1'b1;
            tgt_drive  <= 1'b0;
        end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
            stops     <= stops + 1;
            bit_n     <= 0;
            tx_mode   <= 1'b0;
            tgt_drive <= 1'b0;
        end else if (!prev_scl && scl_line) begin
            if (bit_n < 9) bit_n <= bit_n + 1;
            if (!tx_mode && bit_n < 8) shreg <= {shreg[6:0], sda_line};
            if (tx_mode && bit_n == 8) master_ack <= sda_line;
        end else if (prev_scl && !scl_line) begin
            if (bit_n == 8 && !tx_mode) begin
                ack_now = tgt_present && (rx_n != nack_idx) &&
                          (!first_byte || shreg[7:1] == 7'h2A);
                if (rx_n < 8) rx_log[rx_n] <= shreg;
                rx_n       <= rx_n + 1;
                tgt_drive  <= ack_now;
                rd_addr_ok <= first_byte && shreg[0] && ack_now;
                first_byte <= 1'b0;
                if (stretch_en && rx_n == 0) stretch_cnt <= 66;
            end else if (bit_n == 8 && tx_mode) begin
                tgt_drive <= 1'b0;
            end else if (bit_n == 9) begin
                bit_n <= 0;
                if (!tx_mode && rd_addr_ok) begin
                    tx_mode   <= 1'b1;
                    tgt_drive <= !read_byte[7];
                end else begin
                    tgt_drive <= 1'b0;
                end
            end else if (tx_mode && bit_n >= 1 && bit_n <= 7) begin
                tgt_drive <= !read_byte[7 - bit_n];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_target();
        tgt_clear = 1'b1;
        @(posedge clk);
        #1;
        tgt_clear = 1'b0;
    endtask

    // Waits (bounded) for cmd_ready, presents one command; returns right after the accept edge.
    task automatic applyStimulus(input logic rw, input logic [6:0] addr,
                                 input logic [7:0] rg, input logic [7:0] wd);
        int w;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL ready_timeout: cmd_ready observed 0 required 1");
        end
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_reg   = rg;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL done_timeout: done observed 0 required 1 within %0d cycles", n);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_rw      = 1'b0;
        cmd_addr    = 7'h00;
        cmd_reg     = 8'h00;
        cmd_wdata   = 8'h00;
        tgt_clear   = 1'b1;
        tgt_present = 1'b1;
        nack_idx    = 99;
        read_byte   = 8'hA5;
        stretch_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        checkOutput("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_ack_err", {31'd0, ack_err}, 32'd0);
        checkOutput("rst_rdata", {24'd0, rdata}, 32'h00);
        rst       = 1'b0;
        tgt_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] write 2A/03 <= 7F");
        clear_target();
        applyStimulus(1'b0, 7'h2A, 8'h03, 8'h7F);
        checkOutput("wr_busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(cycles);
        checkOutput("wr_cycles", cycles, 32'd464);
        checkOutput("wr_busy_in_done", {31'd0, busy}, 32'd1);
        checkOutput("wr_ready_in_done", {31'd0, cmd_ready}, 32'd0);
        checkOutput("wr_ack_err", {31'd0, ack_err}, 32'd0);
        checkOutput("wr_nbytes", rx_n, 32'd3);
        checkOutput("wr_byte0", {24'd0, rx_log[0]}, 32'h54);
        checkOutput("wr_byte1", {24'd0, rx_log[1]}, 32'h03);
        checkOutput("wr_byte2", {24'd0, rx_log[2]}, 32'h7F);
        checkOutput("wr_starts", starts, 32'd1);
        checkOutput("wr_stops", stops, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("wr_done_pulse", {31'd0, done}, 32'd0);
        checkOutput("wr_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("wr_ready_after", {31'd0, cmd_ready}, 32'd1);
        checkOutput("wr_scl_idle", {31'd0, scl_oe}, 32'd0);
        checkOutput("wr_sda_idle", {31'd0, sda_oe}, 32'd0);

        $display("[TB] read 2A/10, target returns A5");
        clear_target();
        applyStimulus(1'b1, 7'h2A, 8'h10, 8'h00);
        wait_done(cycles);
        checkOutput("rd_cycles", cycles, 32'd624);
        checkOutput("rd_rdata", {24'd0, rdata}, 32'hA5);
        checkOutput("rd_ack_err", {31'd0, ack_err}, 32'd0);
        checkOutput("rd_nbytes", rx_n, 32'd3);
        checkOutput("rd_byte0", {24'd0, rx_log[0]}, 32'h54);
        checkOutput("rd_byte1", {24'd0, rx_log[1]}, 32'h10);
        checkOutput("rd_byte2", {24'd0, rx_log[2]}, 32'h55);
        checkOutput("rd_starts", starts, 32'd2);
        checkOutput("rd_master_nack", {31'd0, master_ack}, 32'd1);
        checkOutput("rd_stops", stops, 32'd1);

        $display("[TB] no target present");
        tgt_present = 1'b0;
        clear_target();
        applyStimulus(1'b0, 7'h2A, 8'h03, 8'h7F);
        wait_done(cycles);
        checkOutput("nt_cycles", cycles, 32'd176);
        checkOutput("nt_ack_err", {31'd0, ack_err}, 32'd1);
        checkOutput("nt_rdata_kept", {24'd0, rdata}, 32'hA5);
        checkOutput("nt_nbytes", rx_n, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("nt_stops", stops, 32'd1);
        tgt_present = 1'b1;

        $display("[TB] target NACKs write data byte");
        nack_idx = 2;
        clear_target();
        applyStimulus(1'b0, 7'h2A, 8'h03, 8'h7F);
        wait_done(cycles);
        checkOutput("nd_cycles", cycles, 32'd464);
        checkOutput("nd_ack_err", {31'd0, ack_err}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("nd_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("nd_stops", stops, 32'd1);
        checkOutput("nd_ack_err_held", {31'd0, ack_err}, 32'd1);
        nack_idx = 99;

        $display("[TB] reset in the middle of the register byte");
        clear_target();
        applyStimulus(1'b0, 7'h2A, 8'h03, 8'h7F);
        repeat (200) @(posedge clk);
        #1;
        checkOutput("rm_sda_driven", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rm_scl_released", {31'd0, scl_oe}, 32'd0);
        checkOutput("rm_sda_released", {31'd0, sda_oe}, 32'd0);
        checkOutput("rm_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rm_ready", {31'd0, cmd_ready}, 32'd1);
        clear_target();
        applyStimulus(1'b0, 7'h2A, 8'h03, 8'h7F);
        wait_done(cycles);
        checkOutput("rm_wr_cycles", cycles, 32'd464);
        checkOutput("rm_wr_ack_err", {31'd0, ack_err}, 32'd0);
        checkOutput("rm_wr_byte2", {24'd0, rx_log[2]}, 32'h7F);

`ifdef I2C_CLK_STRETCH_EN
        $display("[TB] target stretches SCL on address ACK");
        stretch_en = 1'b1;
        clear_target();
        applyStimulus(1'b0, 7'h2A, 8'h03, 8'h7F);
        wait_done(cycles);
        checkOutput("st_delay_min", {31'd0, cycles >= 514}, 32'd1);
        checkOutput("st_delay_max", {31'd0, cycles < 600}, 32'd1);
        checkOutput("st_ack_err", {31'd0, ack_err}, 32'd0);
        checkOutput("st_nbytes", rx_n, 32'd3);
        checkOutput("st_byte0", {24'd0, rx_log[0]}, 32'h54);
        checkOutput("st_byte1", {24'd0, rx_log[1]}, 32'h03);
        checkOutput("st_byte2", {24'd0, rx_log[2]}, 32'h7F);
        stretch_en = 1'b0;
`endif

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
